// File: rtl/decoder_ex_pipe.sv
// decoder_ex_pipe
//   Decodes opcode/funct3/funct7 into the EX control word and registers it
//   into the ID/EX slot under a valid/ready handshake, carrying a tag along.
//   Optional M-extension decode (M_EXT=1) and an illegal-instruction flag.
//   After a divide is handed to EX, a busy counter blocks issue for
//   DIV_CYCLES cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill slot contents and busy state
//   in_valid / in_ready   upstream handshake
//   opcode/funct3/funct7  instruction fields [6:0] / [14:12] / [31:25]
//   in_tag                tag accompanying the instruction
//   out_valid / out_ready downstream handshake
//   out_exop              {mdOp (M_EXT only), aluOp, srcBSel, srcASel, cptSel, workEn}
//   out_illegal           decoded op is illegal
//   out_tag               registered tag
//   busy                  divide busy counter nonzero
module decoder_ex_pipe #(
    parameter int TAG_W      = 32,
    parameter int M_EXT      = 0,
    parameter int DIV_CYCLES = 4,
    parameter int EXOP_W     = 8 + 4 * M_EXT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXOP_W-1:0] out_exop,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic [6:0] {
        OP_R     = 7'b0110011,
        OP_I     = 7'b0010011,
        OP_JALR  = 7'b1100111,
        OP_JAL   = 7'b1101111,
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_FENCE = 7'b0001111,
        OP_SYS   = 7'b1110011
    } opcode_e;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic        work_en;
    logic        cpt_sel;
    logic        src_a_sel;
    logic        src_b_sel;
    logic [3:0]  alu_op;
    logic [3:0]  md_op;
    logic        dec_illegal;
    logic [7:0]  base_exop;
    logic [EXOP_W-1:0] dec_exop;
    logic        dec_div;

    always_comb begin
        work_en     = 1'b1;
        cpt_sel     = 1'b0;
        src_a_sel   = 1'b0;
        src_b_sel   = 1'b1;
        alu_op      = '0;
        md_op       = '0;
        dec_illegal = 1'b0;

        case (opcode_e'(opcode))
            OP_R: begin
                src_b_sel = 1'b0;
                if (funct7 == 7'h00) begin
                    alu_op = {1'b0, funct3};
                end else if (funct7 == 7'h20) begin
                    alu_op = {1'b1, funct3};
                    // only SUB and SRA exist in the funct7=0x20 space
                    if (funct3 != 3'b000 && funct3 != 3'b101)
                        dec_illegal = 1'b1;
                end else if (M_EXT != 0 && funct7 == 7'h01) begin
                    md_op = {1'b1, funct3};
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_I: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // shift-immediates take funct7 into account like R-type
                    if (funct7 == 7'h00)
                        alu_op = {1'b0, funct3};
                    else if (funct7 == 7'h20)
                        alu_op = {1'b1, funct3};
                    else
                        alu_op = '0;
                end else begin
                    alu_op = {1'b0, funct3};
                end
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    dec_illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
                    dec_illegal = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                alu_op    = 4'b1111;
                src_a_sel = 1'b1;
            end
            OP_LUI:   cpt_sel   = 1'b1;
            OP_AUIPC: src_a_sel = 1'b1;
            OP_BR:    work_en   = 1'b0;
            OP_LOAD, OP_STORE, OP_FENCE, OP_SYS: begin
            end
            default:  dec_illegal = 1'b1;
        endcase
    end

    assign base_exop = {alu_op, src_b_sel, src_a_sel, cpt_sel, work_en};
    // DIV/DIVU/REM/REMU are mdOp 1_1xx; md_op stays zero without M_EXT
    assign dec_div   = md_op[3] & md_op[2];

    if (M_EXT != 0) begin : g_mext
        assign dec_exop = {md_op, base_exop};
    end else begin : g_base
        logic unused_md;
        assign unused_md = ^md_op[1:0];
        assign dec_exop  = base_exop;
    end

    // ------------------------------------------------------------------
    // ID/EX slot and divide busy counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count;
    logic             slot_div;
    logic             capture;
    logic             handoff;

    assign in_ready = (!out_valid || out_ready) && (count == '0);
    assign capture  = in_valid && in_ready && !flush;
    assign handoff  = out_valid && out_ready;
    assign busy     = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_exop    <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            slot_div    <= 1'b0;
            count       <= '0;
        end else if (flush) begin
            // data fields are deliberately left as they are
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            if (capture) begin
                out_valid   <= 1'b1;
                out_exop    <= dec_exop;
                out_illegal <= dec_illegal;
                out_tag     <= in_tag;
                slot_div    <= dec_div;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end

            if (handoff && slot_div)
                count <= CNT_W'(DIV_CYCLES);
            else if (count != '0)
                count <= count - CNT_W'(1);
        end
    end

endmodule
